// File: rtl/q_deserializer.sv
// q_deserializer: packs the en-qualified q bit stream into WIDTH-bit words
// (LSB-first) and presents each completed or flushed word, its bit count and
// popcount on a valid/ready port. Words lost to backpressure set a sticky
// overrun flag.
// Optional feature macro: Q_DESER_PARITY_EN (registers ^word as parity).
module q_deserializer #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             q,
  input  logic             flush,
  input  logic             out_ready,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic [LW-1:0]    word_len,
  output logic [LW-1:0]    ones,
  output logic             parity,
  output logic             overrun
);

  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [LW-1:0]    cnt;
  logic [WIDTH-1:0] acc_nxt;
  logic [LW-1:0]    cnt_nxt;
  logic             handoff;
  logic             load;

  function automatic logic [LW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [LW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = s + LW'(v[i]);
    end
    return s;
  endfunction

  // Accumulator view including this cycle's sample; decides hand-off and
  // whether the output register can take the word.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    if (en) begin
      acc_nxt = acc | (WIDTH'(q) << cnt);
      cnt_nxt = cnt + LW'(1);
    end
    handoff = (cnt_nxt == LW'(WIDTH)) || (flush && (cnt_nxt != '0));
    // A held word is only replaced if it is being transferred this cycle.
    load    = handoff && ((state == EMPTY) || out_ready);
  end

  assign word_valid = (state == FULL);

  // Accumulator and output register (EMPTY/FULL) with sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      acc      <= '0;
      cnt      <= '0;
      word     <= '0;
      word_len <= '0;
      ones     <= '0;
      overrun  <= 1'b0;
    end else begin
      // The accumulator clears on every hand-off, even a discarded one.
      if (handoff) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end

      if (load) begin
        state    <= FULL;
        word     <= acc_nxt;
        word_len <= cnt_nxt;
        ones     <= popcount(acc_nxt);
      end else if (handoff) begin
        // FULL and not draining: new word dropped, held word untouched.
        overrun  <= 1'b1;
      end else if ((state == FULL) && out_ready) begin
        state    <= EMPTY;
      end
    end
  end

`ifdef Q_DESER_PARITY_EN
  // Parity of the word, captured together with it at hand-off.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= ^acc_nxt;
    end
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_q_deserializer.sv
// Bench for q_deserializer: a frame-level model built from a bit queue is
// compared against the DUT every cycle, plus literal expectations for the
// hand-computed vectors.
module tb_q_deserializer;

  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n, en, q, flush, out_ready;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic [LW-1:0]    word_len, ones;
  logic             parity, overrun;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  q_deserializer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .q(q), .flush(flush),
    .out_ready(out_ready), .word(word), .word_valid(word_valid),
    .word_len(word_len), .ones(ones), .parity(parity), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // ---------------- frame-level reference model ----------------
  bit          frame[$];
  bit          m_valid, m_ovr, m_par;
  int unsigned m_word, m_len, m_ones;
  int unsigned b_word, b_ones;

  always @(posedge clk) begin
    if (!rst_n) begin
      frame.delete();
      m_valid = 0; m_ovr = 0; m_par = 0;
      m_word = 0; m_len = 0; m_ones = 0;
    end else begin
      if (en) frame.push_back(q);
      if (frame.size() == WIDTH || (flush && frame.size() > 0)) begin
        if (m_valid && !out_ready) begin
          m_ovr = 1;
        end else begin
          b_word = 0; b_ones = 0;
          foreach (frame[i]) begin
            b_word = b_word + (int'(frame[i]) << i);
            b_ones = b_ones + frame[i];
          end
          m_word = b_word; m_len = frame.size(); m_ones = b_ones;
`ifdef Q_DESER_PARITY_EN
          m_par = b_ones % 2;
`else
          m_par = 0;
`endif
          m_valid = 1;
        end
        frame.delete();
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs vs model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_word_valid", word_valid, m_valid);
      check("m_overrun", overrun, m_ovr);
      check("m_word", word, m_word);
      check("m_word_len", word_len, m_len);
      check("m_ones", ones, m_ones);
      check("m_parity", parity, m_par);
    end
  end

  // Apply one cycle of inputs, return at the next falling edge.
  task automatic drive(input bit e, input bit d, input bit f, input bit r);
    en = e; q = d; flush = f; out_ready = r;
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] bits, input int n, input bit r, input bit gap);
    for (int i = 0; i < n; i++) begin
      drive(1, bits[i], 0, r);
      if (gap && i != n - 1) drive(0, 1, 0, r);
    end
  endtask

  logic [7:0] pat;

  initial begin
    rst_n = 0; en = 1; q = 1; flush = 0; out_ready = 1;
    @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    check("rst_valid", word_valid, 0);
    check("rst_word", word, 0);
    check("rst_overrun", overrun, 0);
    check("rst_len", word_len, 0);
    rst_n = 1;

    // Full word 0x8D; samples taken during reset must not leak in.
    pat = 8'h8D;
    feed(pat, 8, 1, 0);
    check("full_valid", word_valid, 1);
    check("full_word", word, 8'h8D);
    check("full_len", word_len, 8);
    check("full_ones", ones, 4);
    check("full_parity", parity, 0);
    drive(0, 0, 0, 1);
    check("full_valid_one_cycle", word_valid, 0);

    // Gapped input with q=1 on idle cycles.
    feed(pat, 8, 1, 1);
    check("gap_valid", word_valid, 1);
    check("gap_word", word, 8'h8D);
    drive(0, 0, 0, 1);

    // Flush of a 3-bit partial word.
    pat = 8'h03;
    feed(pat, 3, 1, 0);
    drive(0, 0, 1, 1);
    check("flush_word", word, 8'h03);
    check("flush_len", word_len, 3);
    check("flush_ones", ones, 2);
    drive(0, 0, 0, 1);

    // Flush together with a 4th sample.
    feed(pat, 3, 1, 0);
    drive(1, 1, 1, 1);
    check("flush4_word", word, 8'h0B);
    check("flush4_len", word_len, 4);
    drive(0, 0, 0, 1);

    // Parity of flushed 0x07.
    pat = 8'h07;
    feed(pat, 2, 1, 0);
    drive(1, 1, 1, 1);
    check("par_word", word, 8'h07);
`ifdef Q_DESER_PARITY_EN
    check("par_parity", parity, 1);
`else
    check("par_parity", parity, 0);
`endif
    drive(0, 0, 0, 1);

    // Flush with nothing accumulated does nothing.
    drive(0, 0, 1, 1);
    check("empty_flush_valid", word_valid, 0);

    // Backpressure and overrun.
    pat = 8'hFF;
    feed(pat, 8, 0, 0);
    pat = 8'h00;
    feed(pat, 7, 0, 0);
    check("bp_overrun_before", overrun, 0);
    drive(1, 0, 0, 0);
    check("bp_overrun", overrun, 1);
    check("bp_word_held", word, 8'hFF);
    check("bp_valid_held", word_valid, 1);
    drive(0, 0, 0, 1);
    check("bp_drained", word_valid, 0);
    check("bp_overrun_sticky", overrun, 1);

    // Transfer and hand-off on the same edge keeps the port full.
    pat = 8'hA5;
    feed(pat, 8, 1, 0);
    drive(1, 1, 1, 1);
    check("b2b_valid", word_valid, 1);
    check("b2b_word", word, 8'h01);
    check("b2b_len", word_len, 1);
    drive(0, 0, 0, 1);

    // Continuous input, mixed data, model-checked.
    for (int i = 0; i < 40; i++) drive(1, (i * 7 + i / 3) % 2, 0, 1);
    drive(0, 0, 0, 1);

    // Mid-frame reset drops the partial word and clears overrun.
    pat = 8'h07;
    feed(pat, 3, 1, 0);
    rst_n = 0;
    drive(1, 1, 0, 1);
    rst_n = 1;
    check("midrst_overrun", overrun, 0);
    check("midrst_valid", word_valid, 0);
    pat = 8'h8D;
    feed(pat, 8, 1, 0);
    check("midrst_word", word, 8'h8D);
    drive(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/q_deserializer.md
# q_deserializer

Downstream consumer of the gated-XOR stage's `q`/`en` bit stream. Collects the bits sampled while `en` is high into words of `WIDTH` bits. Each completed or flushed word is presented with its bit count and popcount on a valid/ready output port. Words that complete while the output is still occupied are detected and flagged.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; legal range 2..32.
- `LW`, default `$clog2(WIDTH+1)`: width of the count fields; derived, never overridden.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  sample qualifier; `q` is captured only when `en`=1.
- `q`  in  1  data bit from the upstream gated-XOR stage.
- `flush`  in  1  emit the partial word now.
- `out_ready`  in  1  consumer accepts `word` this cycle.
- `word`  out  WIDTH  assembled word; sample k of the frame is at bit k (LSB-first); unfilled bits are 0.
- `word_valid`  out  1  output holds an untransferred word.
- `word_len`  out  LW  number of valid bits in `word`, 1..WIDTH.
- `ones`  out  LW  popcount of `word`.
- `parity`  out  1  XOR of `word` bits (see Configuration).
- `overrun`  out  1  sticky; a word was lost.

## Operation
- Accumulator: shift/index register `acc[WIDTH-1:0]` plus bit counter `cnt` (0..WIDTH).
  - On `en`=1, `q` is written to `acc[cnt]` and `cnt` increments.
  - `en`=0 cycles are ignored entirely.
- Completion: when the sample that makes `cnt`=WIDTH is taken, a word is ready for hand-off. Hand-off happens on that same edge:
  - `acc`/`cnt` go to the output register.
  - The accumulator clears (`acc`=0, `cnt`=0).
- Flush: `flush`=1 with `cnt`>0 (after including any same-cycle `en` sample) hands off a partial word of `word_len`=`cnt`.
  - `flush` with `cnt`=0 and `en`=0 does nothing.
- Output register: two states, EMPTY and FULL.
  - EMPTY→FULL on hand-off.
  - FULL→EMPTY when `word_valid && out_ready` and no hand-off occurs that cycle.
  - FULL→FULL (new word loaded) when a transfer and a hand-off coincide.
- Overrun: a hand-off while FULL with `out_ready`=0 discards the new word.
  - The held word stays unchanged.
  - `overrun` is set; the accumulator still clears.
  - `overrun` clears only on reset.
- `ones` and `word_len` are computed from `acc`/`cnt` at hand-off and registered with `word`.

## Timing
- Reset (`rst_n`=0 at an edge) sets: `word`=0, `word_valid`=0, `word_len`=0, `ones`=0, `parity`=0, `overrun`=0, `acc`=0, `cnt`=0.
  - Reset takes effect at any point mid-frame; the partial word is lost.
- Latency: `word_valid` is high in the cycle after the edge that sampled the WIDTH-th bit, or after the edge that sampled `flush`.
- `word_valid` and all output fields are stable while `word_valid`=1 and `out_ready`=0.
- Continuous input: `en`=1 every cycle with `out_ready`=1 yields one `word_valid` cycle per WIDTH cycles, with no dropped bits.
- Simultaneous `en` and `flush`: the sample is included in the flushed word. If that sample fills the word, it is a normal full word.
- `out_ready` is ignored while `word_valid`=0.

## Configuration
- `Q_DESER_PARITY_EN` defined: `parity` is registered with each word as `^acc` at hand-off. The parity tree is compiled in.
- `Q_DESER_PARITY_EN` not defined: the parity logic is omitted and `parity` is tied to 0. The port list is unchanged.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `en`=1, `q`=1 → all outputs 0 and `cnt` stays 0.
- Full word, `WIDTH`=8, `out_ready`=1: `q`=1,0,1,1,0,0,0,1 on 8 consecutive `en` cycles → one cycle later:
  - `word`=0x8D, `word_len`=8, `ones`=4.
  - `word_valid` high for exactly 1 cycle.
- Gapped input: same bits with `en`=0 cycles (and `q`=1) between each sample → identical `word`=0x8D; `word_valid` 1 cycle after the 8th sample.
- Flush: samples 1,1,0, then `flush`=1 → `word`=0x03, `word_len`=3, `ones`=2.
  - Flush in the same cycle as a 4th sample `q`=1 → `word`=0x0B, `word_len`=4.
- Backpressure/overrun: `out_ready`=0; feed 0xFF bits, then 0x00 bits →
  - `word`=0xFF is held.
  - `overrun`=1 after the 16th sample.
  - Raising `out_ready` transfers 0xFF and `word_valid` then drops.
- Parity (with `Q_DESER_PARITY_EN`): 0x8D gives `parity`=0; 0x07 flushed at `word_len`=3 gives `parity`=1. Without the macro, `parity`=0 always.
